// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port unified memory between instruction fetch and the
// data stage. One transaction is in flight at a time. Data requests win
// arbitration unless the data streak has reached MAX_D_STREAK while an
// instruction request waits, in which case fetch is served.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   i_req_i/i_addr_i                 instruction read request
//   i_gnt_o/i_rvalid_o/i_rdata_o     instruction grant, read response
//   d_req_i/d_we_i/d_addr_i/d_wdata_i  data request (read or write)
//   d_gnt_o/d_rvalid_o/d_wdone_o/d_rdata_o  data grant, read/write response
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o  memory request side
//   mem_ready_i/mem_rvalid_i/mem_rdata_i       memory handshake and response
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    output logic              i_gnt_o,
    output logic              i_rvalid_o,
    output logic [DATA_W-1:0] i_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic              d_wdone_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ready_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

    state_t            state_r;
    state_t            state_nxt_s;
    logic              d_win_s;
    logic              i_win_s;
    logic              streak_full_s;
    logic [3:0]        streak_r;
    logic [3:0]        streak_nxt_s;
    logic              owner_d_r;
    logic              mem_req_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic              i_rvalid_r;
    logic              d_rvalid_r;
    logic              d_wdone_r;
    logic [DATA_W-1:0] i_rdata_r;
    logic [DATA_W-1:0] d_rdata_r;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Arbitration: grants are a same-cycle handshake with the held request,
    // so they are decoded from the current state and requests.
    always_comb begin
        d_win_s       = 1'b0;
        i_win_s       = 1'b0;
        streak_full_s = i_req_i && (streak_r == STREAK_MAX);
        if (state_r == ST_IDLE) begin
            if (d_req_i && !streak_full_s) begin
                d_win_s = 1'b1;
            end else if (i_req_i) begin
                i_win_s = 1'b1;
            end else begin
                i_win_s = 1'b0;
            end
        end else begin
            d_win_s = 1'b0;
            i_win_s = 1'b0;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (d_win_s || i_win_s) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_ready_i) begin
                    state_nxt_s = mem_we_r ? ST_IDLE : ST_WAIT;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid_i) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Streak counter update: only data grants with a waiting fetch count up
    always_comb begin
        streak_nxt_s = streak_r;
        if (i_win_s) begin
            streak_nxt_s = 4'd0;
        end else if (d_win_s && i_req_i) begin
            streak_nxt_s = (streak_r >= STREAK_MAX) ? STREAK_MAX : (streak_r + 4'd1);
        end else if (d_win_s) begin
            streak_nxt_s = 4'd0;
        end else begin
            streak_nxt_s = streak_r;
        end
    end

    // Request capture, memory-side outputs and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_r    <= 4'd0;
            owner_d_r   <= 1'b0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
            i_rvalid_r  <= 1'b0;
            d_rvalid_r  <= 1'b0;
            d_wdone_r   <= 1'b0;
            i_rdata_r   <= {DATA_W{1'b0}};
            d_rdata_r   <= {DATA_W{1'b0}};
        end else begin
            streak_r   <= streak_nxt_s;
            i_rvalid_r <= 1'b0;
            d_rvalid_r <= 1'b0;
            d_wdone_r  <= 1'b0;
            if (d_win_s) begin
                owner_d_r   <= 1'b1;
                mem_req_r   <= 1'b1;
                mem_we_r    <= d_we_i;
                mem_addr_r  <= d_addr_i;
                mem_wdata_r <= d_wdata_i;
            end else if (i_win_s) begin
                owner_d_r   <= 1'b0;
                mem_req_r   <= 1'b1;
                mem_we_r    <= 1'b0;
                mem_addr_r  <= i_addr_i;
                mem_wdata_r <= {DATA_W{1'b0}};
            end else if ((state_r == ST_REQ) && mem_ready_i) begin
                mem_req_r <= 1'b0;
                d_wdone_r <= mem_we_r;
            end else if ((state_r == ST_WAIT) && mem_rvalid_i) begin
                // Response is routed to whichever port owns the transaction
                if (owner_d_r) begin
                    d_rdata_r  <= mem_rdata_i;
                    d_rvalid_r <= 1'b1;
                end else begin
                    i_rdata_r  <= mem_rdata_i;
                    i_rvalid_r <= 1'b1;
                end
            end else begin
                mem_req_r <= mem_req_r;
            end
        end
    end

    assign i_gnt_o     = i_win_s;
    assign d_gnt_o     = d_win_s;
    assign i_rvalid_o  = i_rvalid_r;
    assign i_rdata_o   = i_rdata_r;
    assign d_rvalid_o  = d_rvalid_r;
    assign d_wdone_o   = d_wdone_r;
    assign d_rdata_o   = d_rdata_r;
    assign mem_req_o   = mem_req_r;
    assign mem_we_o    = mem_we_r;
    assign mem_addr_o  = mem_addr_r;
    assign mem_wdata_o = mem_wdata_r;

endmodule
